// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - 7-seg scan bus decoder (optional input synchronizer: SEG_SCAN_SYNC_EN)
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 4,
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg,
  output logic                    cap_valid,
  output logic [IDXW-1:0]         cap_idx,
  output logic [3:0]              cap_hex,
  output logic                    cap_bad,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] frame_value,
  output logic                    frame_err
);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  logic [NUM_DIGITS-1:0] an_src;
  logic [6:0]            seg_src;

`ifdef SEG_SCAN_SYNC_EN
  logic [NUM_DIGITS-1:0] an_m1_q, an_m2_q;
  logic [6:0]            seg_m1_q, seg_m2_q;

  // Two-flop synchronizer for a display source running on another clock; idles inactive (all high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_m1_q  <= '1;
      an_m2_q  <= '1;
      seg_m1_q <= '1;
      seg_m2_q <= '1;
    end else begin
      an_m1_q  <= an_n;
      an_m2_q  <= an_m1_q;
      seg_m1_q <= seg;
      seg_m2_q <= seg_m1_q;
    end
  end

  assign an_src  = an_m2_q;
  assign seg_src = seg_m2_q;
`else
  assign an_src  = an_n;
  assign seg_src = seg;
`endif

  logic [NUM_DIGITS-1:0] s_an_q;
  logic [6:0]            s_seg_q;
  logic [NUM_DIGITS-1:0] p_an_q;
  logic [6:0]            p_seg_q;

  // Input stage plus a one-cycle-delayed copy used to detect bus changes while settling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_an_q  <= '1;
      s_seg_q <= '1;
      p_an_q  <= '1;
      p_seg_q <= '1;
    end else begin
      s_an_q  <= an_src;
      s_seg_q <= seg_src;
      p_an_q  <= s_an_q;
      p_seg_q <= s_seg_q;
    end
  end

  logic            an_ok;
  logic [IDXW-1:0] an_idx;
  int              low_cnt;

  // Anode is usable only when exactly one line is pulled low; its position is the digit index.
  always_comb begin
    low_cnt = 0;
    an_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an_q[i]) begin
        low_cnt = low_cnt + 1;
        an_idx  = IDXW'(i);
      end
    end
    an_ok = (low_cnt == 1);
  end

  logic [3:0] dec_hex;
  logic       dec_bad;

  // Reverse 7-seg lookup of the active-low {a..g} pattern; unknown patterns flag bad and read 0.
  always_comb begin
    dec_hex = 4'h0;
    dec_bad = 1'b0;
    case (s_seg_q)
      7'b0000001: dec_hex = 4'h0;
      7'b1001111: dec_hex = 4'h1;
      7'b0010010: dec_hex = 4'h2;
      7'b0000110: dec_hex = 4'h3;
      7'b1001100: dec_hex = 4'h4;
      7'b0100100: dec_hex = 4'h5;
      7'b0100000: dec_hex = 4'h6;
      7'b0001111: dec_hex = 4'h7;
      7'b0000000: dec_hex = 4'h8;
      7'b0000100: dec_hex = 4'h9;
      7'b0001000: dec_hex = 4'hA;
      7'b1100000: dec_hex = 4'hB;
      7'b0110001: dec_hex = 4'hC;
      7'b1000010: dec_hex = 4'hD;
      7'b0110000: dec_hex = 4'hE;
      7'b0111000: dec_hex = 4'hF;
      default:    dec_bad = 1'b1;
    endcase
  end

  state_t                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  load_cap;
  logic                  bus_changed;
  logic [NUM_DIGITS-1:0] cap_an_q;

  assign bus_changed = (s_an_q != p_an_q) || (s_seg_q != p_seg_q);

  // State and settle-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: settle on a stable digit, capture once, then hold until the anode moves.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_cap = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (an_ok) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (!an_ok) begin
          state_d = ST_WAIT;
        end else if (bus_changed) begin
          cnt_d = '0;
        end else if (cnt_q == CNTW'(SETTLE_CYCLES - 1)) begin
          state_d  = ST_CAPTURE;
          load_cap = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_CAPTURE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (s_an_q != cap_an_q) begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  logic [IDXW-1:0] cap_idx_q;
  logic [3:0]      cap_hex_q;
  logic            cap_bad_q;

  // Capture registers are loaded as the FSM enters CAPTURE and then hold until the next capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_idx_q <= '0;
      cap_hex_q <= '0;
      cap_bad_q <= 1'b0;
      cap_an_q  <= '1;
    end else if (load_cap) begin
      cap_idx_q <= an_idx;
      cap_hex_q <= dec_hex;
      cap_bad_q <= dec_bad;
      cap_an_q  <= s_an_q;
    end
  end

  assign cap_valid = (state_q == ST_CAPTURE);
  assign cap_idx   = cap_idx_q;
  assign cap_hex   = cap_hex_q;
  assign cap_bad   = cap_bad_q;

  logic [4*NUM_DIGITS-1:0] buf_q, buf_wr;
  logic [NUM_DIGITS-1:0]   mask_q, mask_new;
  logic                    acc_q;
  logic                    frame_valid_q;
  logic [4*NUM_DIGITS-1:0] frame_value_q;
  logic                    frame_err_q;

  // Frame buffer and digit mask as they will look once the current capture is folded in.
  always_comb begin
    buf_wr = buf_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_idx_q == IDXW'(i)) begin
        buf_wr[4*i +: 4] = cap_hex_q;
      end
    end
    mask_new = mask_q | (NUM_DIGITS'(1) << cap_idx_q);
  end

  // Frame assembly: publish the buffer the cycle after the mask fills and start a fresh frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q         <= '0;
      mask_q        <= '0;
      acc_q         <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_value_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      if (state_q == ST_CAPTURE) begin
        buf_q <= buf_wr;
        if (&mask_new) begin
          frame_valid_q <= 1'b1;
          frame_value_q <= buf_wr;
          frame_err_q   <= acc_q | cap_bad_q;
          mask_q        <= '0;
          acc_q         <= 1'b0;
        end else begin
          mask_q <= mask_new;
          acc_q  <= acc_q | cap_bad_q;
        end
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_value = frame_value_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

  localparam int ND   = 8;
  localparam int S    = 4;
  localparam int GAP  = 6;
`ifdef SEG_SCAN_SYNC_EN
  localparam int LAT  = 2;
`else
  localparam int LAT  = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [ND-1:0] an_n;
  logic [6:0]    seg;
  logic          cap_valid;
  logic [2:0]    cap_idx;
  logic [3:0]    cap_hex;
  logic          cap_bad;
  logic          frame_valid;
  logic [31:0]   frame_value;
  logic          frame_err;

  int checks = 0;
  int errors = 0;

  logic [6:0] tbl [16];
  logic [3:0] m_buf [ND];
  logic [ND-1:0] m_mask;
  bit         m_acc;

  seg_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .an_n(an_n), .seg(seg),
    .cap_valid(cap_valid), .cap_idx(cap_idx), .cap_hex(cap_hex), .cap_bad(cap_bad),
    .frame_valid(frame_valid), .frame_value(frame_value), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_table(input logic [6:0] p);
    for (int k = 0; k < 16; k++) if (tbl[k] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_hex(input logic [6:0] p);
    for (int k = 0; k < 16; k++) if (tbl[k] == p) return 4'(k);
    return 4'h0;
  endfunction

  function automatic logic [6:0] rand_bad();
    logic [6:0] p;
    p = 7'($urandom);
    while (in_table(p)) p = 7'($urandom);
    return p;
  endfunction

  function automatic logic [31:0] model_frame();
    logic [31:0] v;
    for (int k = 0; k < ND; k++) v[4*k +: 4] = m_buf[k];
    return v;
  endfunction

  // Apply one anode dwell (optionally switching segments at drive cycle chg_at), followed by a blank gap.
  // Expected: capture happens once the pair has been stable for S+1 drive cycles, S+1 cycles after the
  // start of that stable run (+LAT); segment changes after that are ignored.
  task automatic dwell(input logic [ND-1:0] an, input logic [6:0] s1, input logic [6:0] s2,
                       input int chg_at, input int len);
    int run_start, cap_c, frame_c, idx;
    logic [6:0] cap_pat;
    int chg;
    chg       = (s1 != s2 && chg_at > 1 && chg_at <= len) ? chg_at : 0;
    cap_c     = -1;
    frame_c   = -1;
    cap_pat   = s1;
    idx       = 0;
    if ($countones(~an) == 1) begin
      for (int k = 0; k < ND; k++) if (!an[k]) idx = k;
      if (chg == 0) begin
        if (len >= S + 1) cap_c = 1 + S + 1 + LAT;
      end else if (chg - 1 >= S + 1) begin
        cap_c = 1 + S + 1 + LAT;
      end else begin
        run_start = chg;
        cap_pat   = s2;
        if (len - run_start + 1 >= S + 1) cap_c = run_start + S + 1 + LAT;
      end
    end
    for (int c = 1; c <= len + GAP; c++) begin
      if (c <= len) begin
        an_n = an;
        seg  = (chg != 0 && c >= chg) ? s2 : s1;
      end else begin
        an_n = '1;
        seg  = '1;
      end
      @(posedge clk);
      @(negedge clk);
      chk("cap_valid", cap_valid, c == cap_c);
      if (c == cap_c) begin
        chk("cap_idx", cap_idx, idx);
        chk("cap_hex", cap_hex, ref_hex(cap_pat));
        chk("cap_bad", cap_bad, !in_table(cap_pat));
        m_buf[idx] = ref_hex(cap_pat);
        m_mask[idx] = 1'b1;
        m_acc = m_acc | !in_table(cap_pat);
        if (&m_mask) frame_c = c + 1;
      end
      chk("frame_valid", frame_valid, c == frame_c);
      if (c == frame_c) begin
        chk("frame_value", frame_value, model_frame());
        chk("frame_err", frame_err, m_acc);
        m_mask = '0;
        m_acc  = 1'b0;
      end
    end
  endtask

  task automatic digit(input int d, input logic [6:0] p, input int len);
    dwell(~(ND'(1) << d), p, p, 0, len);
  endtask

  task automatic scan(input logic [31:0] v, input logic [ND-1:0] bad);
    logic [3:0] nib;
    for (int d = ND - 1; d >= 0; d--) begin
      nib = v[4*d +: 4];
      digit(d, bad[d] ? rand_bad() : tbl[nib], 10);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    an_n  = '1;
    seg   = '1;
    #1;
    chk("rst_cap_valid", cap_valid, 0);
    chk("rst_cap_idx", cap_idx, 0);
    chk("rst_cap_hex", cap_hex, 0);
    chk("rst_cap_bad", cap_bad, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_value", frame_value, 0);
    chk("rst_frame_err", frame_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < ND; k++) m_buf[k] = 4'h0;
    m_mask = '0;
    m_acc  = 1'b0;
  endtask

  initial begin
    logic [ND-1:0] an_r;
    logic [6:0]    p1, p2;
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
            7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    reset = 1'b1;
    an_n  = '1;
    seg   = '1;
    repeat (2) @(posedge clk);
    do_reset();

    // Plain frame
    scan(32'h1234ABCD, 8'h00);

    // Short dwell on digit 2 does not capture; frame completes only after a long dwell on it
    for (int d = 7; d >= 3; d--) digit(d, tbl[d], 10);
    digit(2, tbl[2], 3);
    digit(1, tbl[1], 10);
    digit(0, tbl[0], 10);
    digit(2, tbl[9], 6);

    // Blank pattern on digit 0 marks the frame bad; next frame is clean
    for (int d = 7; d >= 1; d--) digit(d, tbl[15 - d], 10);
    digit(0, 7'b1111111, 10);
    scan(32'hCAFE0123, 8'h00);

    // Two anodes low: never a capture
    dwell(8'b11111100, tbl[3], tbl[3], 0, 20);

    // Segment change during HOLD ignored; change during settling restarts the count
    dwell(~8'h08, tbl[5], tbl[6], 8, 10);
    dwell(~8'h10, tbl[1], tbl[7], 3, 10);
    digit(7, tbl[2], 10);
    digit(6, tbl[4], 10);
    do_reset();
    for (int d = 7; d >= 4; d--) digit(d, tbl[d], 10);
    for (int d = 3; d >= 0; d--) digit(d, tbl[d + 8], 10);

    // Table sweep plus invalid patterns
    scan(32'hFEDCBA98, 8'h00);
    scan(32'h76543210, 8'h00);
    scan(32'h0, 8'hFF);
    scan(32'h0, 8'hFF);

    // Randomized dwells
    for (int n = 0; n < 60; n++) begin
      an_r = ($urandom_range(0, 7) == 0) ? ND'($urandom) : ~(ND'(1) << $urandom_range(0, ND - 1));
      p1 = ($urandom_range(0, 4) == 0) ? rand_bad() : tbl[$urandom_range(0, 15)];
      p2 = ($urandom_range(0, 4) == 0) ? rand_bad() : tbl[$urandom_range(0, 15)];
      dwell(an_r, p1, p2, ($urandom_range(0, 2) == 0) ? $urandom_range(2, 12) : 0,
            $urandom_range(2, 12));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
